// File: rtl/keyreg_arbiter.sv
//==============================================================================
// Module   : keyreg_arbiter
// Summary  : Round-robin arbiter that shares a bank of NREG key/IV slots
//            between NREQ requesters. Each access runs IDLE -> ISSUE -> ACK.
//            All outputs are registered.
// Options  : define KEYREG_LOCK_EN to add sticky per-slot write-only locks
//            (adds the lock_i port).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module keyreg_arbiter #(
  parameter int K    = 128,
  parameter int NREQ = 2,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ-1:0]     reqWe_i,
  input  logic [NREQ*AW-1:0]  reqAddr_i,
  input  logic [NREQ*K-1:0]   reqData_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [NREQ-1:0]     ack_o,
  output logic                err_o,
  output logic [K-1:0]        rdata_o,
  output logic                busy_o,
  output logic [NREG-1:0]     regWe_o,
  output logic [K-1:0]        regWriteData_o,
  input  logic [NREG*K-1:0]   regDataRead_i
`ifdef KEYREG_LOCK_EN
  ,
  input  logic [NREG-1:0]     lock_i
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [K-1:0]     data_q, data_d;
  logic             locked_q, locked_d;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic [K-1:0]     rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic [NREG-1:0]  reg_we_q, reg_we_d;
  logic [K-1:0]     reg_wdata_q, reg_wdata_d;

  logic [NREG-1:0]  slot_lock;
  logic [NREG-1:0]  sel_new;
  logic [NREG-1:0]  sel_cur;
  logic [K-1:0]     slot_rd;
  logic             found;
  int               cand;
  int               win;

  // One-hot slot decode; an all-zero result marks an out-of-range address.
  function automatic logic [NREG-1:0] slot_sel(input logic [AW-1:0] a);
    logic [NREG-1:0] s;
    s = '0;
    for (int j = 0; j < NREG; j++) begin
      s[j] = (a == AW'(j));
    end
    return s;
  endfunction

`ifdef KEYREG_LOCK_EN
  logic [NREG-1:0] lock_q, lock_d;

  // Lock bits are sticky until reset.
  always_comb begin
    lock_d = lock_q | lock_i;
  end

  // Lock bit register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lock_q <= '0;
    else          lock_q <= lock_d;
  end

  assign slot_lock = lock_q;
`else
  assign slot_lock = '0;
`endif

  // Read mux for the slot held by the transaction in flight.
  always_comb begin
    sel_cur = slot_sel(addr_q);
    slot_rd = '0;
    for (int j = 0; j < NREG; j++) begin
      if (sel_cur[j]) slot_rd = regDataRead_i[j*K +: K];
    end
  end

  // Next-state, request latching and registered-output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    locked_d    = locked_q;
    gnt_d       = '0;
    ack_d       = '0;
    err_d       = 1'b0;
    rdata_d     = '0;
    reg_we_d    = '0;
    reg_wdata_d = '0;
    found       = 1'b0;
    cand        = 0;
    win         = 0;
    sel_new     = '0;

    case (state_q)
      S_IDLE: begin
        // First pending request at or after the pointer, wrapping around.
        for (int i = 0; i < NREQ; i++) begin
          cand = int'(ptr_q) + i;
          if (cand >= NREQ) cand = cand - NREQ;
          if (!found && req_i[cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        if (found) begin
          idx_d    = IW'(win);
          we_d     = reqWe_i[win];
          addr_d   = reqAddr_i[win*AW +: AW];
          data_d   = reqData_i[win*K +: K];
          sel_new  = slot_sel(addr_d);
          // Lock state is frozen here, so a lock arriving later in this
          // transaction only affects the next one.
          locked_d = |(sel_new & slot_lock);
          gnt_d[win] = 1'b1;
          if (we_d && !locked_d) begin
            reg_we_d    = sel_new;
            reg_wdata_d = (|sel_new) ? data_d : '0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gnt_d[idx_q] = 1'b1;
        ack_d[idx_q] = 1'b1;
        err_d        = !(|sel_cur) || (we_q && locked_q);
        // The bank only captures the write at this edge, so a write returns
        // the latched data rather than the (still old) slot output.
        if ((|sel_cur) && !locked_q) rdata_d = we_q ? data_q : slot_rd;
        state_d = S_ACK;
      end
      S_ACK: begin
        ptr_d   = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, transaction and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      locked_q    <= 1'b0;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      reg_we_q    <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      locked_q    <= locked_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign gnt_o          = gnt_q;
  assign ack_o          = ack_q;
  assign err_o          = err_q;
  assign rdata_o        = rdata_q;
  assign busy_o         = busy_q;
  assign regWe_o        = reg_we_q;
  assign regWriteData_o = reg_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_keyreg_arbiter.sv
//==============================================================================
// Module   : tb_keyreg_arbiter
// Summary  : Self-checking bench for keyreg_arbiter with a transaction-level
//            reference model and a simple register-bank model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_keyreg_arbiter;

  localparam int K    = 128;
  localparam int NREQ = 2;
  localparam int NREG = 4;
  localparam int AW   = 3;

  logic                clock;
  logic                reset_n;
  logic [NREQ-1:0]     req_i;
  logic [NREQ-1:0]     reqWe_i;
  logic [NREQ*AW-1:0]  reqAddr_i;
  logic [NREQ*K-1:0]   reqData_i;
  logic [NREQ-1:0]     gnt_o;
  logic [NREQ-1:0]     ack_o;
  logic                err_o;
  logic [K-1:0]        rdata_o;
  logic                busy_o;
  logic [NREG-1:0]     regWe_o;
  logic [K-1:0]        regWriteData_o;
  logic [NREG*K-1:0]   regDataRead_i;
`ifdef KEYREG_LOCK_EN
  logic [NREG-1:0]     lock_i;
`endif

  int checks = 0;
  int errors = 0;

  keyreg_arbiter #(.K(K), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_i          (req_i),
    .reqWe_i        (reqWe_i),
    .reqAddr_i      (reqAddr_i),
    .reqData_i      (reqData_i),
    .gnt_o          (gnt_o),
    .ack_o          (ack_o),
    .err_o          (err_o),
    .rdata_o        (rdata_o),
    .busy_o         (busy_o),
    .regWe_o        (regWe_o),
    .regWriteData_o (regWriteData_o),
    .regDataRead_i  (regDataRead_i)
`ifdef KEYREG_LOCK_EN
    ,
    .lock_i         (lock_i)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [K-1:0] slot_init(int j);
    return {4{32'hC0DE_0000 + 32'(j)}};
  endfunction

  task automatic chk(string name, logic [K-1:0] act, logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register bank (environment) ----------------
  logic [K-1:0] bank [NREG];
  logic bank_ok = 1'b0;
  always @(posedge clock) begin
    if (!bank_ok) begin
      for (int j = 0; j < NREG; j++) bank[j] <= slot_init(j);
      bank_ok <= 1'b1;
    end else begin
      for (int j = 0; j < NREG; j++) if (regWe_o[j]) bank[j] <= regWriteData_o;
    end
  end
  always_comb begin
    regDataRead_i = '0;
    for (int j = 0; j < NREG; j++) regDataRead_i[j*K +: K] = bank[j];
  end

  // ---------------- reference model ----------------
  int           m_phase;      // 0 waiting, 1 first cycle after pick, 2 ack cycle
  int           m_ptr;
  int           m_idx;
  logic         m_we;
  int           m_addr;
  logic [K-1:0] m_data;
  logic         m_locked;
  logic [K-1:0] m_mem [NREG];
  logic [NREG-1:0] m_written = '0;
  logic [NREG-1:0] m_lock;
  logic [NREQ-1:0] e_gnt, e_ack;
  logic            e_err, e_busy;
  logic [K-1:0]    e_rdata, e_wdata;
  logic [NREG-1:0] e_we;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0; m_ptr <= 0; m_idx <= 0; m_we <= 1'b0; m_addr <= 0;
      m_data <= '0; m_locked <= 1'b0; m_lock <= '0;
      e_gnt <= '0; e_ack <= '0; e_err <= 1'b0; e_busy <= 1'b0;
      e_rdata <= '0; e_wdata <= '0; e_we <= '0;
    end else begin
      int w, a;
      bit got, lk;
      logic [K-1:0] rd;
      got = 0; w = 0;
`ifdef KEYREG_LOCK_EN
      m_lock <= m_lock | lock_i;
`endif
      e_gnt <= '0; e_ack <= '0; e_err <= 1'b0; e_busy <= 1'b0;
      e_rdata <= '0; e_wdata <= '0; e_we <= '0;
      if (m_phase == 0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!got && req_i[(m_ptr + i) % NREQ]) begin
            got = 1; w = (m_ptr + i) % NREQ;
          end
        end
        if (got) begin
          a  = int'(reqAddr_i[w*AW +: AW]);
          lk = (a < NREG) ? m_lock[a] : 1'b0;
          m_idx <= w; m_we <= reqWe_i[w]; m_addr <= a;
          m_data <= reqData_i[w*K +: K]; m_locked <= lk;
          e_gnt <= NREQ'(1) << w;
          e_busy <= 1'b1;
          if (reqWe_i[w] && a < NREG && !lk) begin
            e_we    <= NREG'(1) << a;
            e_wdata <= reqData_i[w*K +: K];
          end
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        e_gnt  <= NREQ'(1) << m_idx;
        e_ack  <= NREQ'(1) << m_idx;
        e_busy <= 1'b1;
        rd = '0;
        if (m_addr >= NREG) begin
          e_err <= 1'b1;
        end else if (m_locked) begin
          e_err <= m_we;
        end else if (m_we) begin
          rd = m_data;
          m_mem[m_addr] <= m_data;
          m_written[m_addr] <= 1'b1;
        end else begin
          rd = m_written[m_addr] ? m_mem[m_addr] : slot_init(m_addr);
        end
        e_rdata <= rd;
        m_phase <= 2;
      end else begin
        m_ptr   <= (m_idx + 1) % NREQ;
        m_phase <= 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_gnt", K'(gnt_o), '0);
      chk("rst_ack", K'(ack_o), '0);
      chk("rst_busy", K'(busy_o), '0);
      chk("rst_we", K'(regWe_o), '0);
      chk("rst_wdata", regWriteData_o, '0);
    end else begin
      chk("gnt", K'(gnt_o), K'(e_gnt));
      chk("ack", K'(ack_o), K'(e_ack));
      chk("busy", K'(busy_o), K'(e_busy));
      chk("we", K'(regWe_o), K'(e_we));
      chk("wdata", regWriteData_o, e_wdata);
      if (e_ack != '0) begin
        chk("err", K'(err_o), K'(e_err));
        chk("rdata", rdata_o, e_rdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(int r, logic we, int addr, logic [K-1:0] d);
    req_i[r] = 1'b1;
    reqWe_i[r] = we;
    reqAddr_i[r*AW +: AW] = AW'(addr);
    reqData_i[r*K +: K] = d;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Issue one access, wait (bounded) for its ack, return err/rdata.
  task automatic do_req(int r, logic we, int addr, logic [K-1:0] d,
                        output logic err, output logic [K-1:0] rd);
    bit seen;
    seen = 0; err = 1'b0; rd = '0;
    @(negedge clock);
    set_req(r, we, addr, d);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (ack_o[r]) begin
        seen = 1; err = err_o; rd = rdata_o;
      end
    end
    req_i[r] = 1'b0;
    chk("ack_seen", K'(seen), K'(1));
  endtask

  localparam logic [K-1:0] D0 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [K-1:0] D1 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [K-1:0] D2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  initial begin
    logic err;
    logic [K-1:0] rd;
    int ack_order [4];
    int ack_cyc [4];
    int n_acks;

    reset_n = 1'b0; req_i = '0; reqWe_i = '0; reqAddr_i = '0; reqData_i = '0;
`ifdef KEYREG_LOCK_EN
    lock_i = '0;
`endif
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Reset: idle with no requests.
    repeat (3) @(negedge clock);
    chk("idle_busy", K'(busy_o), '0);
    chk("idle_gnt", K'(gnt_o), '0);
    chk("idle_rdata", rdata_o, '0);
    chk("idle_we", K'(regWe_o), '0);

    // Write then read slot 2 from requester 0, with pinned timing.
    @(negedge clock);
    set_req(0, 1'b1, 2, D0);
    @(negedge clock);
    chk("wr_we_slot2", K'(regWe_o), K'(4'b0100));
    chk("wr_gnt", K'(gnt_o), K'(2'b01));
    chk("wr_wdata", regWriteData_o, D0);
    @(negedge clock);
    chk("wr_ack", K'(ack_o), K'(2'b01));
    chk("wr_err", K'(err_o), '0);
    chk("wr_rdata", rdata_o, D0);
    chk("wr_we_off", K'(regWe_o), '0);
    req_i[0] = 1'b0;
    @(negedge clock);
    chk("wr_idle", K'(busy_o), '0);
    do_req(0, 1'b0, 2, '0, err, rd);
    chk("rd_slot2", rd, D0);
    chk("rd_err", K'(err), '0);

    // Simultaneous requests from reset: order 0,1,0,1, one ack per 3 cycles.
    do_reset();
    @(negedge clock);
    set_req(0, 1'b0, 0, '0);
    set_req(1, 1'b0, 1, '0);
    n_acks = 0;
    for (int c = 0; c < 20 && n_acks < 4; c++) begin
      @(negedge clock);
      if (ack_o != '0) begin
        ack_order[n_acks] = ack_o[1] ? 1 : 0;
        ack_cyc[n_acks] = c;
        n_acks++;
      end
    end
    req_i = '0;
    chk("rr_count", K'(n_acks), K'(4));
    for (int i = 0; i < 4 && i < n_acks; i++) begin
      chk("rr_order", K'(ack_order[i]), K'(i % 2));
      if (i > 0) chk("rr_spacing", K'(ack_cyc[i] - ack_cyc[i-1]), K'(3));
    end
    chk("rr_first_lat", K'(ack_cyc[0]), K'(1));

    // Out-of-range write from requester 1.
    @(negedge clock);
    set_req(1, 1'b1, 5, D1);
    @(negedge clock);
    chk("oor_we", K'(regWe_o), '0);
    @(negedge clock);
    chk("oor_ack", K'(ack_o), K'(2'b10));
    chk("oor_err", K'(err_o), K'(1));
    chk("oor_rdata", rdata_o, '0);
    req_i[1] = 1'b0;

    // Reset during ISSUE: slot 3 keeps its prior contents.
    do_req(1, 1'b1, 3, D1, err, rd);
    @(negedge clock);
    set_req(0, 1'b1, 3, D2);
    @(posedge clock);
    #1;
    chk("mid_we_on", K'(regWe_o), K'(4'b1000));
    reset_n = 1'b0;
    #1;
    chk("mid_we_async", K'(regWe_o), '0);
    chk("mid_busy_async", K'(busy_o), '0);
    req_i[0] = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("mid_no_ack", K'(ack_o), '0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    chk("mid_no_ack2", K'(ack_o), '0);
    chk("mid_slot_kept", bank[3], D1);
    do_req(0, 1'b0, 3, '0, err, rd);
    chk("mid_rd_slot3", rd, D1);

`ifdef KEYREG_LOCK_EN
    // Lock slot 1, then attempt write and read; slot 0 remains writable.
    @(negedge clock);
    lock_i[1] = 1'b1;
    @(negedge clock);
    lock_i[1] = 1'b0;
    do_req(0, 1'b1, 1, D2, err, rd);
    chk("lk_wr_err", K'(err), K'(1));
    do_req(1, 1'b0, 1, '0, err, rd);
    chk("lk_rd_zero", rd, '0);
    chk("lk_rd_err", K'(err), '0);
    do_req(0, 1'b1, 0, D2, err, rd);
    chk("lk_wr0_err", K'(err), '0);
    chk("lk_wr0_rdata", rd, D2);
`endif

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/keyreg_arbiter.md
# keyreg_arbiter

Round-robin controller that shares a bank of `NREG` single-port `K`-bit storage registers (key/IV slots) between `NREQ` requesters, for example the host bus and the cipher engines. It arbitrates requests, sequences each access through a fixed three-state FSM, and drives each slot's write enable and write data. It muxes slot read data back to the granted requester and returns a one-cycle acknowledge. It sits between the requester ports and the register bank inside the coprocessor datapath.

## Interface
- `K`, 128, data width of one slot
- `NREQ`, 2, number of requesters
- `NREG`, 4, number of register slots
- `AW`, 2, slot address width
- `clock` in 1: rising-edge clock
- `reset_n` in 1: asynchronous, active-low reset
- `req_i` in NREQ: per-requester request, held high until `ack_o` for that requester
- `reqWe_i` in NREQ: 1 = write, 0 = read
- `reqAddr_i` in NREQ*AW: slot address; requester r uses bits [r*AW +: AW]
- `reqData_i` in NREQ*K: write data; requester r uses bits [r*K +: K]
- `gnt_o` out NREQ: one-hot grant, high in ISSUE and ACK
- `ack_o` out NREQ: one-hot, one-cycle completion pulse
- `err_o` out 1: error, valid only with `ack_o`
- `rdata_o` out K: slot read data, valid only with `ack_o`
- `busy_o` out 1: high whenever the FSM is not in IDLE
- `regWe_o` out NREG: one-hot per-slot write enable to the bank
- `regWriteData_o` out K: shared write data to the bank
- `regDataRead_i` in NREG*K: slot outputs concatenated; slot j uses bits [j*K +: K]
- `lock_i` in NREG: per-slot lock request; this port exists only with `KEYREG_LOCK_EN`

## Operation
- **FSM states:** IDLE, ISSUE, ACK. All state and output registers reset asynchronously.
- **IDLE:**
  - When any `req_i` bit is high, select the first set bit at or after `ptr`, searching upward with modulo-`NREQ` wrap.
  - Latch the winner's index, we, addr and data into internal registers, then go to ISSUE.
  - When no request is pending, stay in IDLE.
- **ISSUE:**
  - `gnt_o[idx]` = 1.
  - If the latched operation is a write and it is legal, `regWe_o[addr]` = 1 and `regWriteData_o` = latched data.
  - Go to ACK.
- **ACK:**
  - `ack_o[idx]` = 1 and `rdata_o` = `regDataRead_i[addr]`. For a write, this returns the value just written.
  - `ptr` = (idx+1) mod `NREQ`.
  - Go to IDLE.
- **Illegal access:** an address with `addr >= NREG` produces no write enable, returns `rdata_o` = 0 and sets `err_o` = 1.
- **Output reset values:** `gnt_o`, `ack_o`, `err_o`, `rdata_o`, `busy_o`, `regWe_o` and `regWriteData_o` are all 0. `ptr` = 0 and the state is IDLE.
- **Dropped request:** if `req_i` drops after the winner is latched, the access still completes and `ack_o` still pulses.
- **Request changes while busy:** `req_i`, `reqWe_i`, `reqAddr_i` and `reqData_i` changes outside IDLE have no effect on the transaction in flight.
- **Simultaneous requests:** the round-robin pointer guarantees that no requester waits more than `NREQ`-1 transactions.

## Timing
- **Latency:** with `req_i` high at clock edge E0 in IDLE, ISSUE occupies E0→E1 and `ack_o` is high E1→E2.
- **Throughput:** one transaction every 3 cycles when requests are continuous.
- **Outputs:** every output is registered. `regWe_o` is high for exactly one cycle, and the slot captures the write at the edge that ends ISSUE.
- **Reset mid-transaction:** when `reset_n` is asserted mid-transaction, the transaction is abandoned with no ack, and `regWe_o` drops immediately without waiting for a clock edge.

## Configuration
- **Macro:** `KEYREG_LOCK_EN`.
- **Defined:**
  - Each slot has a lock bit, set when `lock_i[j]` is sampled high. A set lock bit is sticky and is cleared only by `reset_n`.
  - A write to a locked slot produces no `regWe_o` and ack with `err_o` = 1.
  - A read of a locked slot returns `rdata_o` = 0 with `err_o` = 0 (write-only key).
  - A lock bit set in the same cycle as an ISSUE takes effect from the next transaction.
- **Undefined:** the `lock_i` port and the lock bits are absent, and every in-range access is permitted.

## Test plan
- **Reset:** hold `reset_n` low, then release with no requests. Expect all outputs 0, `busy_o` 0 and the FSM staying in IDLE.
- **Write then read:** requester 0 writes 128'h0011…EEFF to slot 2, then reads slot 2. Expect `regWe_o` = 4'b0100 for one cycle, `ack_o` = 2'b01 two cycles after the request, and the read returning the same value with `err_o` = 0.
- **Simultaneous requests:** requesters 0 and 1 request at the same time, repeatedly, from reset. Expect grants in the order 0, 1, 0, 1 and one ack every 3 cycles.
- **Out-of-range address:** with `AW` = 3 and `NREG` = 4, requester 1 writes address 5. Expect no `regWe_o`, `ack_o` = 2'b10, `err_o` = 1 and `rdata_o` = 0.
- **Reset during ISSUE:** assert `reset_n` during ISSUE. Expect `regWe_o` to fall without waiting for a clock edge, no `ack_o`, and the target slot unchanged.
- **Lock (with `KEYREG_LOCK_EN`):** pulse `lock_i[1]`, then write and read slot 1. Expect the write to ack with `err_o` = 1 and no enable, the read to return 0, and a write to slot 0 to still succeed.
